// File: rtl/data_mem_interface_if.sv
// Data-memory bus: data_mem_interface drives it as master, the memory answers as slave.
// mem_rdata is valid in the same cycle as mem_ack.
interface data_mem_interface_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/data_mem_interface.sv
// Load/store bridge to the single-ported data memory: lane mapping, req/ack with timeout, load alignment.
// Optional LSU_MISALIGN_TRAP_EN faults misaligned half/word accesses instead of forcing their offset down.
module data_mem_interface #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [31:0]                 addr_in,
    input  logic                        wr,
    input  logic                        b_e,
    input  logic                        h_e,
    input  logic                        w_e,
    input  logic [7:0]                  st_b,
    input  logic [15:0]                 st_h,
    input  logic [31:0]                 st_w,
    output logic [31:0]                 mrdout,
    output logic                        busy,
    output logic                        done,
    output logic                        fault,
    data_mem_interface_if.master        mem
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_e;
    typedef enum logic [1:0] {SZ_NONE, SZ_B, SZ_H, SZ_W} size_e;

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state_q;
    size_e            size_q;
    logic [1:0]       off_q;
    logic [CNT_W-1:0] cnt_q;
    logic             req_q, we_q, busy_q, done_q, fault_q;
    logic [29:0]      addr_q;
    logic [3:0]       wstrb_q;
    logic [31:0]      wdata_q, mrdout_q;

    size_e       size_d;
    logic [1:0]  off_d;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic [31:0] rshift;
    logic [31:0] load_d;
    logic        reject_d;

    // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        size_d  = SZ_NONE;
        if (w_e)      size_d = SZ_W;
        else if (h_e) size_d = SZ_H;
        else if (b_e) size_d = SZ_B;

        off_d   = addr_in[1:0];
        wstrb_d = 4'b0000;
        wdata_d = st_w;
        case (size_d)
            SZ_B: begin
                wstrb_d = 4'b0001 << off_d;
                wdata_d = {4{st_b}};
            end
            SZ_H: begin
                off_d[0] = 1'b0;
                wstrb_d  = 4'b0011 << off_d;
                wdata_d  = {2{st_h}};
            end
            SZ_W: begin
                off_d   = 2'b00;
                wstrb_d = 4'b1111;
            end
            default: ;
        endcase
        if (!wr) wstrb_d = 4'b0000;
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign reject_d = (size_d == SZ_NONE)
                   || (size_d == SZ_H && addr_in[0])
                   || (size_d == SZ_W && addr_in[1:0] != 2'b00);
`else
    assign reject_d = (size_d == SZ_NONE);
`endif

    // Loaded word is brought down to bit 0 and zero-filled; sign extension is the controller's job.
    assign rshift = mem.mem_rdata >> {off_q, 3'b000};
    always_comb begin
        load_d = rshift;
        case (size_q)
            SZ_B:    load_d = {24'h0, rshift[7:0]};
            SZ_H:    load_d = {16'h0, rshift[15:0]};
            default: ;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            size_q   <= SZ_NONE;
            off_q    <= 2'b00;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            fault_q  <= 1'b0;
            addr_q   <= '0;
            wstrb_q  <= 4'b0000;
            wdata_q  <= '0;
            mrdout_q <= '0;
        end else begin
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (reject_d) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                            we_q    <= wr;
                            addr_q  <= addr_in[31:2];
                            wstrb_q <= wstrb_d;
                            wdata_q <= wdata_d;
                            size_q  <= size_d;
                            off_q   <= off_d;
                            cnt_q   <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_ack) begin
                        state_q  <= S_DONE;
                        req_q    <= 1'b0;
                        done_q   <= 1'b1;
                        mrdout_q <= load_d;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= S_DONE;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        fault_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mrdout        = mrdout_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign fault         = fault_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = {addr_q, 2'b00};
    assign mem.mem_wstrb = wstrb_q;
    assign mem.mem_wdata = wdata_q;

endmodule
